// File: rtl/mem_port_arbiter_if.sv
// Bundle for the fetch port, data port and shared memory port of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Data wins arbitration; a streak counter forces a fetch grant after
// MAX_D_STREAK back-to-back data grants while fetch was waiting.
//
// state   | meaning
// IDLE    | no access outstanding, grants may be issued
// BUSY_IF | fetch access on memory, waiting for mem_ready
// BUSY_D  | data access on memory, waiting for mem_ready
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  mem_port_arbiter_if.slave   bus,
  output logic                busy_o
);
  localparam int BW = DW / 8;
  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t          state_q, state_d;
  logic [3:0]      streak_q, streak_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_gnt, d_gnt;

  // Arbitration, transfer capture and completion handling
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so nothing is accepted mid-reset.
        d_gnt  = rst_n_i && bus.d_req && !(bus.if_req && (streak_q == MAX_S));
        if_gnt = rst_n_i && bus.if_req && !d_gnt;
        if (d_gnt) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_be;
          if (bus.if_req) streak_d = (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
          else            streak_d = 4'd0;
        end else if (if_gnt) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          streak_d    = 4'd0;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rdata_d  = bus.mem_rdata;
          if_rvalid_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rdata_d  = bus.mem_rdata;
          d_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus),
    .busy_o  (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: who owns memory, what was captured, pending responses
  int          m_owner = 0;          // 0 none, 1 fetch, 2 data
  int          m_streak = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_d_rd = 0;
  logic [3:0]  m_be = 0;
  logic        m_we = 0, m_if_rv = 0, m_d_rv = 0;
  bit          started = 0;

  function automatic bit exp_dg();
    return rst_n && m_owner == 0 && bus.d_req && !(bus.if_req && m_streak == MAXS);
  endfunction
  function automatic bit exp_ig();
    return rst_n && m_owner == 0 && bus.if_req && !exp_dg();
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      m_owner = 0; m_streak = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
      m_if_rv = 0; m_d_rv = 0; m_if_rd = 0; m_d_rd = 0;
    end else begin
      m_if_rv = 0; m_d_rv = 0;
      if (m_owner == 0) begin
        if (exp_dg()) begin
          m_streak = bus.if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
          m_owner = 2; m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata; m_be = bus.d_be;
        end else if (exp_ig()) begin
          m_streak = 0;
          m_owner = 1; m_addr = bus.if_addr; m_we = 0; m_wdata = 0; m_be = 4'hF;
        end
      end else if (bus.mem_ready) begin
        if (m_owner == 1) begin m_if_rd = bus.mem_rdata; m_if_rv = 1; end
        else              begin m_d_rd  = bus.mem_rdata; m_d_rv  = 1; end
        m_owner = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("d_gnt",     bus.d_gnt,     exp_dg());
      chk("if_gnt",    bus.if_gnt,    exp_ig());
      chk("mem_req",   bus.mem_req,   m_owner != 0);
      chk("busy",      busy,          m_owner != 0);
      chk("mem_we",    bus.mem_we,    m_we);
      chk("mem_addr",  bus.mem_addr,  m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_be",    bus.mem_be,    m_be);
      chk("if_rvalid", bus.if_rvalid, m_if_rv);
      chk("d_rvalid",  bus.d_rvalid,  m_d_rv);
      chk("if_rdata",  bus.if_rdata,  m_if_rd);
      chk("d_rdata",   bus.d_rdata,   m_d_rd);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  string seq;

  initial begin
    rst_n = 1'b0;
    bus.if_req = 1; bus.if_addr = 32'h0; bus.d_req = 1; bus.d_we = 0;
    bus.d_addr = 32'h100; bus.d_wdata = 0; bus.d_be = 4'hF;
    bus.mem_ready = 0; bus.mem_rdata = 0;

    // Reset held three cycles with both requests up
    step(); step(); step();
    neg();
    chk("rst d_gnt", bus.d_gnt, 0);
    chk("rst if_gnt", bus.if_gnt, 0);
    chk("rst mem_req", bus.mem_req, 0);
    chk("rst d_rdata", bus.d_rdata, 0);

    // Zero-wait load at 0x100
    @(posedge clk); #1;
    rst_n = 1; bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    neg(); chk("load gnt c0", bus.d_gnt, 1);
    step(); bus.d_req = 0;
    neg(); chk("load mem_req c1", bus.mem_req, 1); chk("load mem_addr c1", bus.mem_addr, 32'h100);
    step();
    neg(); chk("load d_rvalid c2", bus.d_rvalid, 1); chk("load d_rdata c2", bus.d_rdata, 32'hDEADBEEF);
    chk("load if_rvalid c2", bus.if_rvalid, 0);

    // Fetch with three wait states
    step(); bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_ready = 0;
    neg(); chk("wait gnt c0", bus.if_gnt, 1);
    step(); bus.if_req = 0;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("wait addr", bus.mem_addr, 32'h40); chk("wait be", bus.mem_be, 4'hF); chk("wait busy", busy, 1);
      step();
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEF00D;
    neg(); chk("wait addr c4", bus.mem_addr, 32'h40); chk("wait if_rvalid c4", bus.if_rvalid, 0);
    step();
    neg(); chk("wait if_rvalid c5", bus.if_rvalid, 1); chk("wait if_rdata c5", bus.if_rdata, 32'hCAFEF00D);

    // Starvation bound: both requests held high, zero-wait memory
    step(); bus.if_req = 1; bus.d_req = 1; bus.d_addr = 32'h300; bus.if_addr = 32'h80;
    seq = "";
    for (int i = 0; i < 20; i++) begin
      neg();
      if (bus.d_gnt) seq = {seq, "D"};
      if (bus.if_gnt) seq = {seq, "I"};
      step();
    end
    n_vec++;
    if (seq != "DDDDIDDDDI") begin
      n_err++;
      $display("FAIL grant order: got %s expected DDDDIDDDDI", seq);
    end
    bus.if_req = 0; bus.d_req = 0;
    step(); step();

    // Store, with a fetch request arriving while busy
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_be = 4'h3;
    bus.mem_ready = 0; bus.mem_rdata = 32'h55AA55AA;
    neg(); chk("store gnt", bus.d_gnt, 1);
    step(); bus.d_req = 0; bus.d_we = 0; bus.if_req = 1; bus.if_addr = 32'h44;
    for (int i = 0; i < 2; i++) begin
      neg(); chk("store mem_we", bus.mem_we, 1); chk("store mem_wdata", bus.mem_wdata, 32'h12345678);
      chk("store mem_be", bus.mem_be, 4'h3); chk("store if_gnt busy", bus.if_gnt, 0);
      step();
    end
    bus.mem_ready = 1;
    neg(); chk("store if_gnt c3", bus.if_gnt, 0);
    step();
    neg(); chk("store d_rvalid", bus.d_rvalid, 1); chk("store if_gnt idle", bus.if_gnt, 1);
    step(); bus.if_req = 0;
    neg(); chk("store d_rvalid once", bus.d_rvalid, 0);
    step();

    // Reset in the middle of a data access
    bus.d_req = 1; bus.d_addr = 32'h500; bus.mem_ready = 0;
    neg(); chk("mrst gnt", bus.d_gnt, 1);
    step(); bus.d_req = 0; rst_n = 0;
    step(); rst_n = 1; bus.mem_ready = 1;
    neg(); chk("mrst mem_req", bus.mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      neg(); chk("mrst d_rvalid", bus.d_rvalid, 0);
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's instruction-fetch port and data load/store port onto one shared, single-ported memory interface. It owns the address/write-data steering toward memory and sequences each access as a request, grant, memory wait and response. Data accesses have priority over fetch, and a streak counter bounds how long fetch can be starved. It sits between the core's fetch/LSU stages and the unified instruction/data memory.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (byte enables are DW/8)
- `MAX_D_STREAK`, 4, maximum consecutive data grants while fetch is waiting (range 1–15)

- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: synchronous, active-low reset
- `if_req` in 1: fetch request
- `if_addr` in AW: fetch address
- `if_gnt` out 1: fetch request accepted (combinational)
- `if_rvalid` out 1: fetch data valid, one-cycle pulse
- `if_rdata` out DW: fetch read data
- `d_req` in 1: data request
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in AW: data address
- `d_wdata` in DW: store data
- `d_be` in DW/8: store byte enables
- `d_gnt` out 1: data request accepted (combinational)
- `d_rvalid` out 1: load data valid or store complete, one-cycle pulse
- `d_rdata` out DW: load data
- `mem_req` out 1: memory access active
- `mem_we` out 1: memory write
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_be` out DW/8: memory byte enables
- `mem_ready` in 1: memory completes the current access this cycle
- `mem_rdata` in DW: memory read data, valid when `mem_ready`
- `busy` out 1: 1 when the state is not IDLE

## Operation
**States:** IDLE, BUSY_IF, BUSY_D.

**Arbitration** happens only in IDLE:
- `d_gnt = d_req && !(if_req && streak==MAX_D_STREAK)`.
- `if_gnt = if_req && !d_gnt`.
- At most one grant is asserted per cycle. Both grants are 0 outside IDLE.

**Transfer:** a transfer occurs when req && gnt. At that clock edge:
- Capture addr/we/wdata/be into the `mem_*` registers.
- Set `mem_req` = 1.
- Move to BUSY_IF or BUSY_D.
- For fetch grants, `mem_we` = 0 and `mem_be` = all ones.

**Busy states:**
- Outputs are held stable while `mem_ready` = 0. Wait length is unbounded.
- When `mem_ready` = 1: clear `mem_req`, register `mem_rdata` into the owner's rdata, pulse the owner's rvalid next cycle, and return to IDLE.
- For stores, `d_rvalid` still pulses. `d_rdata` is then don't-care but is loaded from `mem_rdata` anyway.

**Streak counter** (4-bit):
- On a d transfer with `if_req` = 1: streak increments, saturating at MAX_D_STREAK.
- On a d transfer with `if_req` = 0: streak clears.
- On any if transfer: streak clears.

**Other rules:**
- `if_rdata` and `d_rdata` hold their last value between pulses.
- Requests arriving during BUSY_* are ignored. Requesters hold req and payload until they see gnt.
- Reset mid-access abandons the access. No rvalid is issued for it, and `mem_req` is 0 from the next cycle.
- `mem_ready` in IDLE is ignored.

## Timing
**Reset values** (`rst_n` = 0 at an edge):
- State IDLE, streak 0.
- `mem_req`, `mem_we`, `if_rvalid`, `d_rvalid` = 0.
- `mem_addr`, `mem_wdata`, `mem_be`, `if_rdata`, `d_rdata` = 0.
- `busy` = 0.

**Minimum latency:**
- Cycle 0: req and gnt.
- Cycle 1: `mem_req` = 1, with `mem_ready` = 1.
- Cycle 2: rvalid = 1 and state is IDLE. A new gnt is possible in this same cycle.
- Each wait cycle on `mem_ready` adds one cycle.

**Throughput:** one access per 2 cycles at zero wait states. The memory sees `mem_req` high for exactly one cycle per access when `mem_ready` is tied high.

**Simultaneous events:**
- rvalid for the old access and gnt for a new access in the same cycle is legal.
- Requester payload is sampled only on the transfer edge.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `if_req` = `d_req` = 1 -> all outputs 0, no gnt. Release -> `d_gnt` = 1 in the first IDLE cycle.
- **Zero-wait load:** `d_req` with addr 0x100, `mem_ready` = 1, `mem_rdata` = 0xDEADBEEF -> `d_gnt` in cycle 0, `mem_req` / `mem_addr` = 0x100 in cycle 1, `d_rvalid` with `d_rdata` = 0xDEADBEEF in cycle 2, `if_rvalid` = 0.
- **Wait states:** fetch addr 0x40, `mem_ready` low for 3 cycles -> `mem_addr` stable at 0x40 with `mem_be` = 0xF for 4 cycles, `busy` = 1 throughout, `if_rvalid` in cycle 5, `if_rdata` = `mem_rdata`.
- **Starvation bound:** `if_req` and `d_req` held high continuously, `MAX_D_STREAK` = 4 -> grant order D, D, D, D, IF, D, D, D, D, IF.
- **Store:** `d_we` = 1, addr 0x200, wdata 0x12345678, be 0x3 -> `mem_we` = 1 with the same values on `mem_*`, `d_rvalid` pulses once. A fetch request during BUSY_D receives no gnt until IDLE.
- **Mid-access reset:** assert `rst_n` = 0 in BUSY_D with `mem_ready` = 0 -> `mem_req` = 0 next cycle, and no `d_rvalid` afterwards even if `mem_ready` pulses.
